// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, counter widths and phase helper for the UART receive controller
package uart_rx_pkg;
    localparam int BIT_CNT_W = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_START = '0;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_CHECK  = 3'd5
    } state_t;
    // true in the phases where the line is being sampled and the counters run
    function automatic logic is_counting(input state_t s);
        return s inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter modulo i_mod with a bit counter advanced on each wrap
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_mod,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_wrap
);
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    assign o_wrap     = r_edge_cnt == i_mod - PRESCALE_W'(1);
    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    // dropping the enable clears both counters so the next phase sequence starts from bit 0, edge 0
    always_ff @(posedge CLK) begin
        if (RST || !i_en) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= BIT_START;
        end else if (o_wrap) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
        end else begin
            r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer driving phase enables and qualifying each frame
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  frame_err
);
    state_t                r_state, w_next;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en, r_par_err_q;
    logic                  w_wrap, w_start, w_cnt_en, w_err;
    assign w_start = (r_state == ST_IDLE || r_state == ST_CHECK) && !rx_in;
    assign w_err   = stp_err | r_par_err_q;
    uart_rx_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .i_en       (w_cnt_en),
        .i_mod      (r_prescale),
        .o_edge_cnt (edge_cnt),
        .o_bit_cnt  (bit_cnt),
        .o_wrap     (w_wrap)
    );
    // next state, phase enables and the CHECK-cycle verdict
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   w_next = rx_in ? ST_IDLE : ST_START;
            ST_START:  w_next = w_wrap ? ST_DATA : ST_START;
            ST_DATA:
                if (bit_cnt == BIT_CNT_W'(1) && edge_cnt == '0 && strt_glitch)
                    w_next = ST_IDLE;
                else if (bit_cnt == BIT_CNT_W'(DATA_W) && w_wrap)
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: w_next = w_wrap ? ST_STOP : ST_PARITY;
            ST_STOP:   w_next = w_wrap ? ST_CHECK : ST_STOP;
            ST_CHECK:  w_next = rx_in ? ST_IDLE : ST_START;
            default:   w_next = ST_IDLE;
        endcase
        w_cnt_en    = is_counting(r_state) && is_counting(w_next);
        dat_samp_en = is_counting(r_state);
        strt_chk_en = r_state == ST_START;
        deser_en    = r_state == ST_DATA;
        par_chk_en  = r_state == ST_PARITY;
        stp_chk_en  = r_state == ST_STOP;
        data_valid  = r_state == ST_CHECK && !w_err;
        frame_err   = r_state == ST_CHECK && w_err;
    end
    // state register
    always_ff @(posedge CLK) begin
        r_state <= RST ? ST_IDLE : w_next;
    end
    // oversampling ratio and parity mode are frozen for the whole frame once the start edge is seen
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale <= '0;
            r_par_en   <= 1'b0;
        end else if (w_start) begin
            r_prescale <= prescale;
            r_par_en   <= par_en;
        end
    end
    // parity verdict is taken on entering STOP, when the parity checker has seen the whole parity bit
    always_ff @(posedge CLK) begin
        if (RST || r_state == ST_IDLE)
            r_par_err_q <= 1'b0;
        else if (r_state == ST_STOP && edge_cnt == '0)
            r_par_err_q <= par_err;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: frame-position model of the receive controller with directed frame scenarios
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    logic       CLK, RST, rx_in, par_en, strt_glitch, par_err, stp_err;
    logic [5:0] prescale, edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err;

    uart_rx_ctrl #(.PRESCALE_W(6), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0, bad = 0, cyc = 0, ts = 0;
    int dv_n = 0, fe_n = 0, pc_n = 0, dv_at = 0, dv_prev = 0, fe_at = 0;
    bit started = 0;

    // model: m_k is the cycle offset inside the frame (-1 when idle), frame length is n_bits*P, then one verdict cycle
    int m_k = -1, m_p = 0;
    bit m_par = 0, m_perr = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        int nb;
        nb = m_par ? DW + 3 : DW + 2;
        if (RST) begin
            m_k <= -1; m_p <= 0; m_par <= 0; m_perr <= 0;
        end else if (m_k < 0 || m_k == nb * m_p) begin
            if (!rx_in) begin
                m_k <= 0; m_p <= int'(prescale); m_par <= par_en; m_perr <= 0;
            end else begin
                m_k <= -1; m_perr <= 0;
            end
        end else if (m_k == m_p && strt_glitch) begin
            m_k <= -1;
        end else begin
            if (m_k == (nb - 1) * m_p) m_perr <= par_err;
            m_k <= m_k + 1;
        end
    end

    always @(negedge CLK) begin
        int nb, b, xe, xb;
        logic [4:0] en;
        logic xdv, xfe;
        if (started) begin
            nb = m_par ? DW + 3 : DW + 2;
            xe = 0; xb = 0; en = '0; xdv = 0; xfe = 0;
            if (m_k >= 0 && m_k == nb * m_p) begin
                xdv = !(stp_err | m_perr);
                xfe = !xdv;
            end else if (m_k >= 0) begin
                b  = m_k / m_p;
                xe = m_k % m_p;
                xb = b;
                en = {1'b1, b == 0, b >= 1 && b <= DW, m_par && b == DW + 1, b == nb - 1};
            end
            chk("edge_cnt", int'(edge_cnt), xe);
            chk("bit_cnt", int'(bit_cnt), xb);
            chk("enables", int'({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en}), int'(en));
            chk("pulses", int'({data_valid, frame_err}), int'({xdv, xfe}));
            if (data_valid) begin dv_n++; dv_prev = dv_at; dv_at = cyc; end
            if (frame_err) begin fe_n++; fe_at = cyc; end
            if (par_chk_en) pc_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #2; end
    endtask

    // drives one frame's line waveform from its start cycle; settings are disturbed halfway to prove they are frozen
    task automatic send(input logic [7:0] d, input int p, input int p2, input bit pe, input int ncyc);
        int k, b;
        prescale = 6'(p); par_en = pe; rx_in = 1'b0; ts = cyc;
        for (int i = 0; i < ncyc; i++) begin
            tick(1);
            if (i == ncyc / 2) begin prescale = 6'(p2); par_en = !pe; end
            k = cyc - ts - 1;
            b = k / p;
            rx_in = (b == 0) ? 1'b0 : (b <= DW) ? d[b-1] : (pe && b == DW + 1) ? ^d : 1'b1;
        end
    endtask

    initial begin
        int n0, f0, p0, t1;
        RST = 1; rx_in = 1; prescale = 6'd8; par_en = 0; strt_glitch = 0; par_err = 0; stp_err = 0;
        @(posedge CLK); #2;
        started = 1;
        tick(2);
        chk("reset_outs", int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
        RST = 0;
        tick(3);

        n0 = dv_n; f0 = fe_n;
        send(8'hA5, 8, 8, 0, 81); tick(3);
        chk("t1_dv_count", dv_n - n0, 1);
        chk("t1_dv_lat", dv_at - ts, 81);
        chk("t1_fe_count", fe_n - f0, 0);

        n0 = dv_n; p0 = pc_n;
        send(8'h3C, 8, 8, 1, 89); tick(3);
        chk("t2_par_cycles", pc_n - p0, 8);
        chk("t2_dv_lat", dv_at - ts, 89);
        chk("t2_dv_count", dv_n - n0, 1);

        n0 = dv_n; f0 = fe_n;
        strt_glitch = 1;
        send(8'h00, 8, 8, 0, 10);
        chk("t3_idle_after_glitch", int'({dat_samp_en, edge_cnt, bit_cnt}), 0);
        rx_in = 1; strt_glitch = 0;
        tick(100);
        chk("t3_no_pulses", (dv_n - n0) + (fe_n - f0), 0);

        n0 = dv_n; f0 = fe_n;
        stp_err = 1;
        send(8'h5A, 16, 16, 0, 161); tick(2);
        stp_err = 0; tick(2);
        chk("t4_fe_lat", fe_at - ts, 161);
        chk("t4_fe_count", fe_n - f0, 1);
        chk("t4_dv_count", dv_n - n0, 0);

        n0 = dv_n; f0 = fe_n;
        par_err = 1;
        send(8'h81, 8, 8, 1, 89); tick(2);
        par_err = 0; tick(2);
        chk("t5_fe_lat", fe_at - ts, 89);
        chk("t5_dv_count", dv_n - n0, 0);

        n0 = dv_n;
        send(8'hC3, 8, 16, 0, 81);
        t1 = ts;
        send(8'h7E, 16, 16, 0, 161); tick(3);
        chk("t6_dv_count", dv_n - n0, 2);
        chk("t6_frame2_start", ts - t1, 81);
        chk("t6_dv_gap", dv_at - dv_prev, 161);

        n0 = dv_n; f0 = fe_n;
        send(8'h99, 8, 8, 0, 36);
        RST = 1; rx_in = 1;
        tick(1);
        chk("t7_reset_outs", int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err}), 0);
        RST = 0;
        tick(3);
        chk("t7_no_pulses", (dv_n - n0) + (fe_n - f0), 0);
        send(8'h96, 32, 32, 0, 321); tick(3);
        chk("t7_dv_lat", dv_at - ts, 321);
        chk("t7_dv_count", dv_n - n0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
